// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler that shares one UART TX serializer among NUM_REQ byte producers.
//   It grants one requester at a time, latches that byte onto TxData and pulses transmit
//   for one cycle. It then follows the TX busy flag through the frame and can insert an
//   idle gap before the next grant. If busy never rises after transmit, the frame is
//   abandoned with a one-cycle timeout pulse.
//
// Ports
//   clk       in   1          system clock, rising edge
//   reset     in   1          synchronous, active-high
//   req       in   NUM_REQ    req[i]: requester i holds a byte to send
//   req_data  in   8*NUM_REQ  byte of requester i at [8i+7:8i]
//   grant     out  NUM_REQ    one-hot 1-cycle pulse: byte of requester i consumed
//   grant_id  out  3          index of the most recent grant
//   transmit  out  1          1-cycle start pulse to TX
//   TxData    out  8          byte to TX, stable from transmit until the next grant
//   busy      in   1          TX busy
//   active    out  1          high whenever the FSM is not idle
//   timeout   out  1          1-cycle pulse: busy never rose within BUSY_TIMEOUT clocks
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GAP_CYCLES   = 0,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [2:0]           grant_id,
    output logic                 transmit,
    output logic [7:0]           TxData,
    input  logic                 busy,
    output logic                 active,
    output logic                 timeout
);

    // One counter serves both the busy timeout and the inter-frame gap.
    localparam int unsigned CntMax = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] BusyLast =
        CntW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [CntW-1:0] GapLast =
        CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        last_q, last_d;

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic               transmit_q, transmit_d;
    logic [7:0]         txdata_q, txdata_d;
    logic               active_q, active_d;
    logic               timeout_q, timeout_d;

    logic               hi_valid;
    logic [2:0]         hi_idx, lo_idx, pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [7:0]         pick_data;
    logic               launch;
    logic               tmo_hit;

    // Round-robin pick: the lowest asserted index above last_q wins, otherwise wrap around
    // to the lowest asserted index. The most recent winner therefore ranks last.
    always_comb begin
        hi_valid = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_idx = 3'(k);
                if (k > int'(last_q)) begin
                    hi_valid = 1'b1;
                    hi_idx   = 3'(k);
                end
            end
        end
        pick_idx = hi_valid ? hi_idx : lo_idx;

        pick_onehot = '0;
        pick_data   = 8'h00;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (pick_idx == 3'(k)) begin
                pick_onehot[k] = 1'b1;
                pick_data      = req_data[8*k +: 8];
            end
        end
    end

    // A new frame may only start from idle with the TX free; requests elsewhere are ignored.
    assign launch  = (state_q == StIdle) && (|req) && !busy;
    // busy takes precedence over the terminal count.
    assign tmo_hit = (state_q == StWaitBusy) && !busy && (cnt_q == BusyLast);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
                cnt_d   = '0;
            end
            StWaitBusy: begin
                if (busy) begin
                    state_d = StWaitDone;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGap;
                        cnt_d   = '0;
                    end
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic: next values of the registered outputs and the round-robin pointer
    always_comb begin
        grant_d    = '0;
        transmit_d = 1'b0;
        txdata_d   = txdata_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        timeout_d  = tmo_hit;
        active_d   = (state_d != StIdle);
        if (launch) begin
            grant_d    = pick_onehot;
            transmit_d = 1'b1;
            txdata_d   = pick_data;
            grant_id_d = pick_idx;
            last_d     = pick_idx;
        end
    end

    // Output registers; the pointer resets to the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q    <= '0;
            grant_id_q <= '0;
            transmit_q <= 1'b0;
            txdata_q   <= 8'h00;
            active_q   <= 1'b0;
            timeout_q  <= 1'b0;
            last_q     <= 3'(NUM_REQ - 1);
        end else begin
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            transmit_q <= transmit_d;
            txdata_q   <= txdata_d;
            active_q   <= active_d;
            timeout_q  <= timeout_d;
            last_q     <= last_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign transmit = transmit_q;
    assign TxData   = txdata_q;
    assign active   = active_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter. The main DUT has GAP_CYCLES=0; a second instance with
//   GAP_CYCLES=3 covers the inter-frame gap. Expected grants go into a queue and a
//   monitor compares them whenever the main DUT presents grant/transmit.
module tb_uart_tx_arbiter;

    localparam int unsigned Frame = 5;   // busy cycles produced by the TX model
    localparam int unsigned Gap1  = 3;
    localparam int unsigned Tmo   = 16;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [2:0]  grant_id;
    logic        transmit;
    logic [7:0]  tx_data;
    logic        busy;
    logic        active;
    logic        timeout;

    logic [3:0]  req_g;
    logic [31:0] data_g;
    logic [3:0]  grant_g;
    logic [2:0]  grant_id_g;
    logic        transmit_g;
    logic [7:0]  tx_data_g;
    logic        busy_g;
    logic        active_g;
    logic        timeout_g;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    bit   tx_auto  = 1'b0;
    int   tx_left  = 0;
    bit   chk_fall = 1'b0;
    bit   fell     = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .GAP_CYCLES   (0),
        .BUSY_TIMEOUT (Tmo)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .grant_id (grant_id),
        .transmit (transmit),
        .TxData   (tx_data),
        .busy     (busy),
        .active   (active),
        .timeout  (timeout)
    );

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .GAP_CYCLES   (Gap1),
        .BUSY_TIMEOUT (Tmo)
    ) u_dut_gap (
        .clk      (clk),
        .reset    (reset),
        .req      (req_g),
        .req_data (data_g),
        .grant    (grant_g),
        .grant_id (grant_id_g),
        .transmit (transmit_g),
        .TxData   (tx_data_g),
        .busy     (busy_g),
        .active   (active_g),
        .timeout  (timeout_g)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] data_of(input int id);
        case (id)
            0:       return 8'hD9;
            1:       return 8'h2B;
            2:       return 8'h3C;
            default: return 8'h4D;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input int id);
        exp_t e;
        e.id   = 3'(id);
        e.data = data_of(id);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = 4'b0000;
        req_g    = 4'b0000;
        busy     = 1'b0;
        busy_g   = 1'b0;
        tx_left  = 0;
        tx_auto  = 1'b0;
        chk_fall = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_sb_empty(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d grants pending after %0d cycles, expected 0", name, sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(active), 0);
    endtask

    task automatic wait_transmit(input string name);
        int n = 0;
        while (!transmit && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(transmit), 1);
    endtask

    // TX model: busy rises right after transmit is seen and stays high for Frame cycles.
    initial begin : tx_model
        forever begin
            @(negedge clk);
            if (tx_auto && !reset) begin
                if (transmit) begin
                    busy    = 1'b1;
                    tx_left = Frame;
                end else if (tx_left > 0) begin
                    tx_left--;
                    if (tx_left == 0) begin
                        busy = 1'b0;
                        fell = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (grant != 4'b0000 || transmit) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: grant %b grant_id %0d, expected none",
                             grant, grant_id);
                end else begin
                    e = sb.pop_front();
                    check("sb_grant", 32'(grant), 32'(1) << e.id);
                    check("sb_grant_id", 32'(grant_id), 32'(e.id));
                    check("sb_txdata", 32'(tx_data), 32'(e.data));
                    check("sb_transmit", 32'(transmit), 1);
                    if (chk_fall) begin
                        check("sb_busy_fell_between_grants", 32'(fell), 1);
                    end
                end
                fell = 1'b0;
            end
        end
    end

    initial begin : stim
        int k;
        reset    = 1'b1;
        req      = 4'b0000;
        req_g    = 4'b0000;
        busy     = 1'b0;
        busy_g   = 1'b0;
        req_data = 32'h4D3C2BD9;
        data_g   = 32'h44332211;

        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_transmit", 32'(transmit), 0);
        check("rst_txdata", 32'(tx_data), 0);
        check("rst_active", 32'(active), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_gap_active", 32'(active_g), 0);
        check("rst_gap_transmit", 32'(transmit_g), 0);

        // 1: single request, one-cycle latency, active until busy has fallen
        do_reset();
        tx_auto = 1'b1;
        expect_grant(0);
        req = 4'b0001;
        @(negedge clk);
        check("t1_transmit_latency", 32'(transmit), 1);
        check("t1_grant_latency", 32'(grant), 32'b0001);
        req = 4'b0000;
        k = 0;
        while (active && k < 50) begin
            @(negedge clk);
            k++;
        end
        // WAIT_BUSY 1 cycle, WAIT_DONE until the edge after busy drops
        check("t1_active_cycles", k, Frame + 1);
        check("t1_txdata_held_idle", 32'(tx_data), 32'hD9);

        // 2: req 0 and 2 held -> 0,2,0,2 with a busy fall between grants
        do_reset();
        tx_auto  = 1'b1;
        fell     = 1'b1;
        chk_fall = 1'b1;
        expect_grant(0);
        expect_grant(2);
        expect_grant(0);
        expect_grant(2);
        req = 4'b0101;
        wait_sb_empty("t2_alternating");
        req = 4'b0000;
        wait_idle("t2_idle");
        chk_fall = 1'b0;

        // 3: all four held -> 0,1,2,3,0,1,2,3
        do_reset();
        tx_auto = 1'b1;
        for (int i = 0; i < 8; i++) expect_grant(i % 4);
        req = 4'b1111;
        wait_sb_empty("t3_round_robin");
        req = 4'b0000;
        wait_idle("t3_idle");

        // 4: busy never rises -> timeout, then req1 granted again
        do_reset();
        expect_grant(1);
        expect_grant(1);
        req = 4'b0010;
        wait_transmit("t4_first_transmit");
        k = 0;
        while (!timeout && k < 40) begin
            @(negedge clk);
            k++;
        end
        // ISSUE edge, then BUSY_TIMEOUT counting edges in WAIT_BUSY
        check("t4_timeout_latency", k, Tmo + 1);
        check("t4_idle_at_timeout", 32'(active), 0);
        @(negedge clk);
        check("t4_timeout_pulse_width", 32'(timeout), 0);
        check("t4_regrant_req1", 32'(grant), 32'b0010);
        req = 4'b0000;
        wait_sb_empty("t4_sb");

        // 5: busy held externally blocks the grant until it falls
        do_reset();
        busy = 1'b1;
        expect_grant(3);
        req = 4'b1000;
        k = 0;
        repeat (6) begin
            @(negedge clk);
            if (grant != 4'b0000 || transmit) k++;
        end
        check("t5_no_grant_while_busy", k, 0);
        check("t5_idle_while_busy", 32'(active), 0);
        busy = 1'b0;
        @(negedge clk);
        check("t5_grant_after_busy_falls", 32'(grant), 32'b1000);
        check("t5_transmit_after_busy_falls", 32'(transmit), 1);
        req = 4'b0000;
        wait_sb_empty("t5_sb");

        // 6: reset during WAIT_DONE, then requester 0 wins first again
        do_reset();
        tx_auto = 1'b1;
        expect_grant(2);
        req = 4'b0100;
        wait_transmit("t6_first_transmit");
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check("t6_active_in_wait_done", 32'(active), 1);
        reset   = 1'b1;
        tx_left = 0;
        busy    = 1'b0;
        @(negedge clk);
        check("t6_reset_active", 32'(active), 0);
        check("t6_reset_transmit", 32'(transmit), 0);
        check("t6_reset_grant", 32'(grant), 0);
        check("t6_reset_grant_id", 32'(grant_id), 0);
        check("t6_reset_txdata", 32'(tx_data), 0);
        reset = 1'b0;
        expect_grant(0);
        req = 4'b0101;
        @(negedge clk);
        check("t6_req0_wins_after_reset", 32'(grant), 32'b0001);
        req = 4'b0000;
        wait_idle("t6_idle");

        // 7: GAP_CYCLES=3 instance, back-to-back requests
        do_reset();
        req_g = 4'b0011;
        k = 0;
        while (!transmit_g && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t7_first_grant", 32'(grant_g), 32'b0001);
        check("t7_first_txdata", 32'(tx_data_g), 32'h11);
        busy_g = 1'b1;
        repeat (3) @(negedge clk);
        busy_g = 1'b0;
        k = 0;
        while (!transmit_g && k < 50) begin
            @(negedge clk);
            k++;
        end
        // busy drops half a cycle before its sampling edge; transmit follows
        // GAP_CYCLES+1 edges after that edge
        check("t7_gap_latency", k, Gap1 + 2);
        check("t7_second_grant", 32'(grant_g), 32'b0010);
        check("t7_second_grant_id", 32'(grant_id_g), 1);
        check("t7_second_txdata", 32'(tx_data_g), 32'h22);
        req_g = 4'b0000;

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
